// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults, channel operation codes and address-width helper
package clkdiv_pkg;

    localparam int unsigned DEF_RST_DIV = 100000;

    typedef enum logic [1:0] {
        OP_COUNT,
        OP_TERM,
        OP_IDLE,
        OP_SYNC
    } ch_op_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one programmable divider channel producing a tick pulse and a square wave
module tick_channel
    import clkdiv_pkg::*;
#(
    parameter int          CW      = 32,
    parameter int unsigned RST_DIV = DEF_RST_DIV
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          i_en,
    input  logic          i_sync,
    input  logic          i_we,
    input  logic [CW-1:0] i_div,
    output logic          o_tick,
    output logic          o_sqw,
    output logic          o_pend
);

    localparam logic [CW-1:0] RST_VAL = CW'(RST_DIV);

    logic [CW-1:0] r_cnt, r_div, r_shd;
    logic          r_pend, r_tick, r_sqw;
    ch_op_e        w_op;
    logic          w_adopt;

    // a pending shadow is taken at every period boundary: sync, idle/parked or terminal count
    always_comb begin
        w_op    = i_sync ? OP_SYNC :
                  (!i_en || r_div == '0) ? OP_IDLE :
                  (r_cnt == r_div - 1'b1) ? OP_TERM : OP_COUNT;
        w_adopt = r_pend && (w_op != OP_COUNT);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt  <= '0;
            r_div  <= RST_VAL;
            r_shd  <= RST_VAL;
            r_pend <= 1'b0;
            r_tick <= 1'b0;
            r_sqw  <= 1'b0;
        end else begin
            r_cnt  <= (w_op == OP_COUNT) ? r_cnt + 1'b1 : '0;
            r_tick <= (w_op == OP_TERM);
            r_sqw  <= (w_op == OP_SYNC) ? 1'b0 : (w_op == OP_TERM) ? ~r_sqw : r_sqw;
            r_div  <= (i_we && i_sync) ? i_div : w_adopt ? r_shd : r_div;
            r_shd  <= i_we ? i_div : r_shd;
            r_pend <= i_we ? !i_sync : (w_adopt ? 1'b0 : r_pend);
        end
    end

    assign o_tick = r_tick;
    assign o_sqw  = r_sqw;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable clock-enable tick and square-wave generator
module clk_tick_gen
    import clkdiv_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          CW      = 32,
    parameter int unsigned RST_DIV = DEF_RST_DIV,
    localparam int         AW      = addr_w(NCH)
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [NCH-1:0] ch_en,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [CW-1:0]  cfg_div,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sqw,
    output logic [NCH-1:0] pend
);

    logic [NCH-1:0] w_we;

    // out-of-range addresses match no channel, so such writes fall away
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_we[i] = cfg_we && (cfg_addr == AW'(i));
        tick_channel #(
            .CW      (CW),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk    (clk),
            .clr_n  (clr_n),
            .i_en   (ch_en[i]),
            .i_sync (sync),
            .i_we   (w_we[i]),
            .i_div  (cfg_div),
            .o_tick (tick[i]),
            .o_sqw  (sqw[i]),
            .o_pend (pend[i])
        );
    end

endmodule
